axi_lite_slave_mem: RTL and testbench
=====================================

AXI_LITE_SLAVE_MEM -- requirements
Module: axi_lite_slave_mem

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port list SHALL be, clock and reset first:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous reset, active high.
- ms_arvalid  in  1  read address valid from master.
- ms_araddr  in  4  read address.
- sm_arready  out  1  read address accepted.
- sm_rvalid  out  1  read data valid.
- sm_rdata  out  4  read data.
- ms_rready  in  1  master ready for read data.
- ms_awvalid  in  1  write address valid.
- ms_awaddr  in  4  write address.
- sm_awready  out  1  write address accepted.
- ms_wvalid  in  1  write data valid.
- ms_wdata  in  4  write data.
- sm_wready  out  1  write data accepted.
- sm_bvalid  out  1  write response valid (tied 0 without AXI_SLV_BRESP_EN).
- ms_bready  in  1  master ready for response (ignored without AXI_SLV_BRESP_EN).
REQ-003 Storage SHALL be 16 entries x 4 bits, indexed directly by the 4-bit address; there is no response-code output, and every access completes as OKAY.

Function
REQ-004 A handshake SHALL be valid and ready both high at a rising edge.
REQ-005 Read FSM SHALL have states R_IDLE (sm_arready=1, sm_rvalid=0) and R_DATA (sm_arready=0, sm_rvalid=1).
REQ-006 An AR handshake in R_IDLE at edge N SHALL load sm_rdata from mem[ms_araddr] and enter R_DATA, so sm_rvalid is high from cycle N+1.
REQ-007 In R_DATA, sm_rvalid and sm_rdata SHALL hold stable until an R handshake; that handshake SHALL return to R_IDLE. Maximum throughput is one read per 2 cycles.
REQ-008 Write FSM SHALL have states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
- W_IDLE: sm_awready=1, sm_wready=1.
- W_HAVE_ADDR: sm_awready=0, sm_wready=1.
- W_HAVE_DATA: sm_awready=1, sm_wready=0.
- W_RESP: both ready low, sm_bvalid=1.
REQ-009 From W_IDLE:
- AW handshake only: capture the address, go to W_HAVE_ADDR.
- W handshake only: capture the data, go to W_HAVE_DATA.
- Both handshakes at the same edge: commit directly.
REQ-010 Commit SHALL write mem[addr]=data at the edge where the second of the AW/W pair is accepted; that edge uses the incoming value for whichever half arrives on it.
REQ-011 After commit, the FSM SHALL enter W_RESP with AXI_SLV_BRESP_EN; without it, it SHALL return to W_IDLE.
REQ-012 In W_RESP, sm_bvalid SHALL stay high until ms_bready; that handshake SHALL return to W_IDLE at the next cycle.
REQ-013 If an AR handshake and a write commit hit the same address at the same edge, the read SHALL return the pre-write data.
REQ-014 Read and write FSMs SHALL operate independently and concurrently.
REQ-015 Valids deasserted before a handshake SHALL leave state unchanged; no request is latched without a handshake.

Reset
REQ-016 While reset is high at an edge:
- Both FSMs SHALL go to their idle states.
- All 16 memory entries SHALL clear to 0.
- sm_rdata SHALL go to 0 and sm_rvalid and sm_bvalid to 0; sm_arready, sm_awready and sm_wready SHALL be 1 from the first cycle after reset.
REQ-017 Reset mid-transaction SHALL discard any captured address or data and any pending response without writing memory.

Configuration
REQ-018 Macro AXI_SLV_BRESP_EN defined SHALL compile in the W_RESP state and the B channel per REQ-012.
REQ-019 Macro AXI_SLV_BRESP_EN undefined SHALL remove W_RESP, tie sm_bvalid to 0 and ignore ms_bready; the write path then accepts a new AW/W pair in the cycle after commit.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Reset, then read addr 4'h7 with rready=1 -> rvalid at N+1, rdata=4'h0, arready low one cycle.
- AW=4'h3 and W=4'hA at the same edge, then read 4'h3 -> rdata=4'hA; with the macro, bvalid held until bready.
- AW=4'h5 at edge N, W=4'h9 at edge N+3 -> mem[5] unchanged until edge N+3; read 4'h5 afterwards returns 4'h9.
- Read rready held low 5 cycles -> rvalid and rdata stable for 5 cycles; arready=0 throughout.
- AR 4'h2 at the same edge as a commit of 4'hF to 4'h2 (old value 4'h6) -> rdata=4'h6; the next read returns 4'hF.
- Reset asserted in W_HAVE_ADDR -> mem unchanged (all 0); awready=1 and wready=1 after reset.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// AXI-Lite style slave over a 16 x 4-bit register file, every access completes OKAY.
// Latency: read data is valid one cycle after AR; a write commits on the edge that accepts the second of its AW/W pair.
// Backpressure: rvalid/rdata and bvalid hold until the master's ready; optional B channel under `AXI_SLV_BRESP_EN.
module axi_lite_slave_mem (
   input  logic       clk,
   input  logic       reset,
   input  logic       ms_arvalid,
   input  logic [3:0] ms_araddr,
   output logic       sm_arready,
   output logic       sm_rvalid,
   output logic [3:0] sm_rdata,
   input  logic       ms_rready,
   input  logic       ms_awvalid,
   input  logic [3:0] ms_awaddr,
   output logic       sm_awready,
   input  logic       ms_wvalid,
   input  logic [3:0] ms_wdata,
   output logic       sm_wready,
   output logic       sm_bvalid,
   input  logic       ms_bready
);

   typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;
`ifdef AXI_SLV_BRESP_EN
   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_t;
`else
   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA} w_state_t;
`endif

   r_state_t   r_state_q, r_state_d;
   w_state_t   w_state_q, w_state_d;
   logic [3:0] rdata_q, rdata_d;
   logic [3:0] waddr_q, waddr_d;
   logic [3:0] wdata_q, wdata_d;
   logic [3:0] mem_q [16];

   logic       aw_hs, w_hs;
   logic       commit;
   logic [3:0] commit_addr, commit_data;

   assign sm_arready = (r_state_q == R_IDLE);
   assign sm_rvalid  = (r_state_q == R_DATA);
   assign sm_rdata   = rdata_q;
   assign sm_awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_DATA);
   assign sm_wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_ADDR);

`ifdef AXI_SLV_BRESP_EN
   assign sm_bvalid = (w_state_q == W_RESP);
`else
   logic unused_bready;
   assign sm_bvalid     = 1'b0;
   assign unused_bready = ms_bready;
`endif

   assign aw_hs = ms_awvalid && sm_awready;
   assign w_hs  = ms_wvalid && sm_wready;

   // Read FSM: sample the array on AR (pre-write value on a same-edge commit), hold until R handshake.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         R_IDLE: begin
            if (ms_arvalid) begin
               rdata_d   = mem_q[ms_araddr];
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (ms_rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Write FSM: collect AW and W in either order, commit when the pair completes.
   always_comb begin
      w_state_d   = w_state_q;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      commit      = 1'b0;
      commit_addr = ms_awaddr;
      commit_data = ms_wdata;
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
            end else if (aw_hs) begin
               waddr_d   = ms_awaddr;
               w_state_d = W_HAVE_ADDR;
            end else if (w_hs) begin
               wdata_d   = ms_wdata;
               w_state_d = W_HAVE_DATA;
            end
         end
         W_HAVE_ADDR: begin
            if (w_hs) begin
               commit      = 1'b1;
               commit_addr = waddr_q;
            end
         end
         W_HAVE_DATA: begin
            if (aw_hs) begin
               commit      = 1'b1;
               commit_data = wdata_q;
            end
         end
`ifdef AXI_SLV_BRESP_EN
         W_RESP: begin
            if (ms_bready) w_state_d = W_IDLE;
         end
`endif
         default: w_state_d = W_IDLE;
      endcase
      if (commit) begin
`ifdef AXI_SLV_BRESP_EN
         w_state_d = W_RESP;
`else
         w_state_d = W_IDLE;
`endif
      end
   end

   // State, captured halves and storage; reset drops any partial write without touching memory contents beyond clearing.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         w_state_q <= W_IDLE;
         rdata_q   <= 4'h0;
         waddr_q   <= 4'h0;
         wdata_q   <= 4'h0;
         for (int i = 0; i < 16; i++) mem_q[i] <= 4'h0;
      end else begin
         r_state_q <= r_state_d;
         w_state_q <= w_state_d;
         rdata_q   <= rdata_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
         if (commit) mem_q[commit_addr] <= commit_data;
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Bench for axi_lite_slave_mem: directed scenarios then randomized traffic against an array model.
// Inputs driven and outputs sampled on the falling edge.
// Works with or without AXI_SLV_BRESP_EN defined.
module tb_axi_lite_slave_mem;

   logic       clk = 1'b0;
   logic       reset;
   logic       ms_arvalid;
   logic [3:0] ms_araddr;
   logic       sm_arready;
   logic       sm_rvalid;
   logic [3:0] sm_rdata;
   logic       ms_rready;
   logic       ms_awvalid;
   logic [3:0] ms_awaddr;
   logic       sm_awready;
   logic       ms_wvalid;
   logic [3:0] ms_wdata;
   logic       sm_wready;
   logic       sm_bvalid;
   logic       ms_bready;

   int tests = 0;
   int fails = 0;
   logic [3:0] ref_mem [16];

   axi_lite_slave_mem dut (
      .clk        (clk),
      .reset      (reset),
      .ms_arvalid (ms_arvalid),
      .ms_araddr  (ms_araddr),
      .sm_arready (sm_arready),
      .sm_rvalid  (sm_rvalid),
      .sm_rdata   (sm_rdata),
      .ms_rready  (ms_rready),
      .ms_awvalid (ms_awvalid),
      .ms_awaddr  (ms_awaddr),
      .sm_awready (sm_awready),
      .ms_wvalid  (ms_wvalid),
      .ms_wdata   (ms_wdata),
      .sm_wready  (sm_wready),
      .sm_bvalid  (sm_bvalid),
      .ms_bready  (ms_bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ms_arvalid = 1'b0; ms_araddr = 4'h0; ms_rready = 1'b0;
      ms_awvalid = 1'b0; ms_awaddr = 4'h0;
      ms_wvalid  = 1'b0; ms_wdata  = 4'h0; ms_bready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = 4'h0;
   endtask

   // Read one address; R handshake withheld for 'hold' cycles after rvalid rises.
   task automatic rd(input logic [3:0] addr, input logic [3:0] exp, input int hold);
      chk("rd_arready_idle", sm_arready, 1);
      ms_arvalid = 1'b1; ms_araddr = addr; ms_rready = (hold == 0);
      @(negedge clk);
      ms_arvalid = 1'b0; ms_rready = 1'b0;
      chk("rd_rvalid", sm_rvalid, 1);
      chk("rd_rdata", sm_rdata, exp);
      chk("rd_arready_busy", sm_arready, 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("rd_hold_rvalid", sm_rvalid, 1);
         chk("rd_hold_rdata", sm_rdata, exp);
         chk("rd_hold_arready", sm_arready, 0);
      end
      ms_rready = 1'b1;
      @(negedge clk);
      ms_rready = 1'b0;
      chk("rd_rvalid_done", sm_rvalid, 0);
      chk("rd_arready_back", sm_arready, 1);
   endtask

   // Called one cycle after the commit edge: B channel behaviour, then write path back to idle.
   task automatic finish_b(input int bdly);
`ifdef AXI_SLV_BRESP_EN
      chk("b_bvalid", sm_bvalid, 1);
      chk("b_awready_low", sm_awready, 0);
      chk("b_wready_low", sm_wready, 0);
      for (int i = 0; i < bdly; i++) begin
         @(negedge clk);
         chk("b_bvalid_hold", sm_bvalid, 1);
      end
      ms_bready = 1'b1;
      @(negedge clk);
      ms_bready = 1'b0;
`endif
      chk("b_bvalid_off", sm_bvalid, 0);
      chk("b_awready_idle", sm_awready, 1);
      chk("b_wready_idle", sm_wready, 1);
   endtask

   // mode 0: AW and W together; 1: AW first; 2: W first. 'gap' idle cycles between halves.
   task automatic wr(input logic [3:0] addr, input logic [3:0] data, input int mode, input int gap, input int bdly);
      if (mode == 0) begin
         ms_awvalid = 1'b1; ms_awaddr = addr; ms_wvalid = 1'b1; ms_wdata = data;
         @(negedge clk);
         ms_awvalid = 1'b0; ms_wvalid = 1'b0;
      end else if (mode == 1) begin
         ms_awvalid = 1'b1; ms_awaddr = addr;
         @(negedge clk);
         ms_awvalid = 1'b0; ms_awaddr = ~addr;
         chk("wr_have_addr_aw", sm_awready, 0);
         chk("wr_have_addr_w", sm_wready, 1);
         repeat (gap) @(negedge clk);
         chk("wr_gap_aw", sm_awready, 0);
         ms_wvalid = 1'b1; ms_wdata = data;
         @(negedge clk);
         ms_wvalid = 1'b0;
      end else begin
         ms_wvalid = 1'b1; ms_wdata = data;
         @(negedge clk);
         ms_wvalid = 1'b0; ms_wdata = ~data;
         chk("wr_have_data_aw", sm_awready, 1);
         chk("wr_have_data_w", sm_wready, 0);
         repeat (gap) @(negedge clk);
         chk("wr_gap_w", sm_wready, 0);
         ms_awvalid = 1'b1; ms_awaddr = addr;
         @(negedge clk);
         ms_awvalid = 1'b0;
      end
      ref_mem[addr] = data;
      finish_b(bdly);
   endtask

   // AR and a same-edge AW+W commit; the read must see the value from before the write.
   task automatic rw_same(input logic [3:0] ra, input logic [3:0] wa, input logic [3:0] wd, input int bdly);
      logic [3:0] exp;
      exp = ref_mem[ra];
      ms_arvalid = 1'b1; ms_araddr = ra; ms_rready = 1'b1;
      ms_awvalid = 1'b1; ms_awaddr = wa; ms_wvalid = 1'b1; ms_wdata = wd;
      @(negedge clk);
      ms_arvalid = 1'b0; ms_awvalid = 1'b0; ms_wvalid = 1'b0;
      ref_mem[wa] = wd;
      chk("rw_rvalid", sm_rvalid, 1);
      chk("rw_rdata_old", sm_rdata, exp);
      @(negedge clk);
      ms_rready = 1'b0;
      chk("rw_rvalid_done", sm_rvalid, 0);
      finish_b(bdly);
   endtask

   initial begin
      // Reset state
      do_reset();
      chk("rst_arready", sm_arready, 1);
      chk("rst_rvalid", sm_rvalid, 0);
      chk("rst_rdata", sm_rdata, 0);
      chk("rst_awready", sm_awready, 1);
      chk("rst_wready", sm_wready, 1);
      chk("rst_bvalid", sm_bvalid, 0);

      // Read of a cleared entry
      rd(4'h7, 4'h0, 0);

      // Simultaneous AW/W then read back
      wr(4'h3, 4'hA, 0, 0, 3);
      rd(4'h3, 4'hA, 0);

      // AW at N, W at N+3; a read in between still sees the old contents
      ms_awvalid = 1'b1; ms_awaddr = 4'h5;
      @(negedge clk);
      ms_awvalid = 1'b0;
      chk("split_have_addr", sm_wready & ~sm_awready, 1);
      rd(4'h5, 4'h0, 0);
      ms_wvalid = 1'b1; ms_wdata = 4'h9;
      @(negedge clk);
      ms_wvalid = 1'b0;
      ref_mem[5] = 4'h9;
      finish_b(1);
      rd(4'h5, 4'h9, 0);

      // Read with rready held low for 5 cycles
      rd(4'h3, 4'hA, 5);

      // Same-edge read and write to one address
      wr(4'h2, 4'h6, 0, 0, 0);
      rw_same(4'h2, 4'h2, 4'hF, 2);
      rd(4'h2, 4'hF, 0);

      // Reset while an address is captured: nothing is written
      ms_awvalid = 1'b1; ms_awaddr = 4'h9;
      @(negedge clk);
      ms_awvalid = 1'b0;
      chk("pre_rst_have_addr", sm_awready, 0);
      do_reset();
      chk("mid_rst_awready", sm_awready, 1);
      chk("mid_rst_wready", sm_wready, 1);
      ms_wvalid = 1'b1; ms_wdata = 4'hC;
      @(negedge clk);
      ms_wvalid = 1'b0;
      chk("post_rst_have_data", sm_wready, 0);
      ms_awvalid = 1'b1; ms_awaddr = 4'h1;
      @(negedge clk);
      ms_awvalid = 1'b0;
      ref_mem[1] = 4'hC;
      finish_b(0);
      rd(4'h9, 4'h0, 0);
      rd(4'h2, 4'h0, 0);
      rd(4'h1, 4'hC, 0);

      // Randomized traffic against the array model
      for (int n = 0; n < 120; n++) begin
         int op;
         logic [3:0] a, b, d;
         op = $urandom_range(0, 3);
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         d = 4'($urandom_range(0, 15));
         case (op)
            0: rd(a, ref_mem[a], $urandom_range(0, 3));
            1, 2: wr(a, d, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3));
            default: rw_same(a, b, d, $urandom_range(0, 2));
         endcase
      end
      for (int i = 0; i < 16; i++) rd(4'(i), ref_mem[i], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
